// File: rtl/n64_vinfo_detect_pkg.sv
// n64_vinfo_detect_pkg: shared sync bit indices, defaults and the vinfo register layout.
package n64_vinfo_detect_pkg;
    localparam int LCNT_W_DEF     = 10;
    localparam int PAL_THRESH_DEF = 288;
    localparam int SY_NVSYNC      = 3;
    localparam int SY_NHSYNC      = 1;
    typedef struct packed {
        logic [1:0] data_cnt;
        logic       n64_480i;
        logic       vmode;
        logic       ndo_deblur;
        logic       n15bit_mode;
    } vinfo_t;
    localparam vinfo_t VINFO_RST = '{data_cnt: 2'b00, n64_480i: 1'b0, vmode: 1'b0,
                                     ndo_deblur: 1'b1, n15bit_mode: 1'b1};
endpackage

// File: rtl/n64_vinfo_detect_if.sv
// n64_vinfo_detect_if: N64 video-side inputs and the demux parameter word.
interface n64_vinfo_detect_if;
    logic       ndsync;
    logic [3:0] sync;
    logic       ndeblur;
    logic       n15bit;
    logic [5:0] vinfo;
    modport master (output ndsync, sync, ndeblur, n15bit, input vinfo);
    modport slave  (input ndsync, sync, ndeblur, n15bit, output vinfo);
endinterface

// File: rtl/n64_sync_edge.sv
// n64_sync_edge: nVSYNC/nHSYNC falling-edge strobes, evaluated once per pixel group.
module n64_sync_edge (
    input  logic clk,
    input  logic nrst,
    input  logic ndsync,
    input  logic nvsync,
    input  logic nhsync,
    output logic vs_fall,
    output logic hs_fall
);
    logic vs_prev, hs_prev;
    always_ff @(posedge clk) begin
        if (!nrst) begin
            vs_prev <= 1'b1;
            hs_prev <= 1'b1;
        end else if (!ndsync) begin
            vs_prev <= nvsync;
            hs_prev <= nhsync;
        end
    end
    assign vs_fall = !ndsync && vs_prev && !nvsync;
    assign hs_fall = !ndsync && hs_prev && !nhsync;
endmodule

// File: rtl/n64_vinfo_detect.sv
// n64_vinfo_detect: derives the demux parameter word from VCLK/nDSYNC/D[3:0].
// Mode fields only move at the nVSYNC falling edge so the demux sees constant parameters per frame.
module n64_vinfo_detect
    import n64_vinfo_detect_pkg::*;
#(
    parameter int LCNT_W     = LCNT_W_DEF,
    parameter int PAL_THRESH = PAL_THRESH_DEF
) (
    input logic               VCLK,
    input logic               nRST,
    n64_vinfo_detect_if.slave bus
);
    vinfo_t            v;
    logic [LCNT_W-1:0] line_cnt;
    logic              field_prev, frame_seen, vs_fall, hs_fall, field, n480i_next;

    n64_sync_edge u_edge (
        .clk    (VCLK),
        .nrst   (nRST),
        .ndsync (bus.ndsync),
        .nvsync (bus.sync[SY_NVSYNC]),
        .nhsync (bus.sync[SY_NHSYNC]),
        .vs_fall(vs_fall),
        .hs_fall(hs_fall)
    );

    assign field      = bus.sync[SY_NHSYNC];
    assign n480i_next = frame_seen && (field != field_prev);

    always_ff @(posedge VCLK) begin
        if (!nRST) begin
            v          <= VINFO_RST;
            line_cnt   <= '0;
            field_prev <= 1'b0;
            frame_seen <= 1'b0;
        end else begin
            v.data_cnt <= bus.ndsync ? v.data_cnt + 2'd1 : 2'b01;
            if (vs_fall) begin
                // a coincident hsync edge is dropped in favour of the clear
                v.vmode       <= line_cnt > LCNT_W'(PAL_THRESH);
                v.n64_480i    <= n480i_next;
                v.ndo_deblur  <= bus.ndeblur || n480i_next;
                v.n15bit_mode <= bus.n15bit;
                line_cnt      <= '0;
                field_prev    <= field;
                frame_seen    <= 1'b1;
            end else if (hs_fall && !(&line_cnt)) begin
                line_cnt <= line_cnt + 1'b1;
            end
        end
    end

    assign bus.vinfo = v;
endmodule
